// File: rtl/inv_sbox_serial.sv
// Purpose: nibble-serial inverse 4-bit S-box layer using one shared S-box lookup.
// Latency: NIBBLES edges from the accept edge to out_valid; no overlap between words.
// Backpressure: result held in S_DONE until out_ready; in_ready only in S_IDLE.
module inv_sbox_serial #(
    parameter int NIBBLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  work, work_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    sbox_in, sbox_out;

    function automatic logic [3:0] inv_sbox(input logic [3:0] y);
        logic [3:0] r;
        case (y)
            4'h0: r = 4'h5;
            4'h1: r = 4'hE;
            4'h2: r = 4'hF;
            4'h3: r = 4'h8;
            4'h4: r = 4'hC;
            4'h5: r = 4'h1;
            4'h6: r = 4'h2;
            4'h7: r = 4'hD;
            4'h8: r = 4'hB;
            4'h9: r = 4'h4;
            4'hA: r = 4'h6;
            4'hB: r = 4'h3;
            4'hC: r = 4'h0;
            4'hD: r = 4'h7;
            4'hE: r = 4'h9;
            default: r = 4'hA;
        endcase
        return r;
    endfunction

    // The single shared S-box looks at whichever nibble the counter selects.
    assign sbox_in  = work[4*cnt +: 4];
    assign sbox_out = inv_sbox(sbox_in);
    assign out_data = work;

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_nxt  = in_data;
                    cnt_nxt   = '0;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                work_nxt[4*cnt +: 4] = sbox_out;
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Returning to idle here means no accept on this same edge.
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, work register and nibble counter; reset drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            work  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_inv_sbox_serial.sv
// Purpose: directed self-checking bench for inv_sbox_serial (16-nibble and 1-nibble builds).
// Latency: checks the exact accept-to-out_valid edge count for every word.
// Backpressure: exercises held out_ready=0, mid-word reset and back-to-back accepts.
module tb_inv_sbox_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  in_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  out_data1;
    logic        busy1;

    int tests;
    int fails;

    inv_sbox_serial #(.NIBBLES(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    inv_sbox_serial #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid on the 16-nibble instance; returns edges waited.
    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Presents one word, checks latency and result; out_ready is 1 so the
    // handshake happens on the edge after out_valid is seen.
    task automatic run_word(input string name, input logic [63:0] din, input logic [63:0] exp);
        int n;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = din;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
        wait_out(n);
        check({name, "_latency"}, 64'(n), 64'd16);
        check({name, "_data"}, out_data, exp);
        @(negedge clk);
        check({name, "_released"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] held;
        tests = 0;
        fails = 0;

        vecs[0] = '{"ascend",  64'h0123456789ABCDEF, 64'h5EF8C12DB463079A};
        vecs[1] = '{"all_c",   64'hCCCCCCCCCCCCCCCC, 64'h0000000000000000};
        vecs[2] = '{"zeros",   64'h0000000000000000, 64'h5555555555555555};
        vecs[3] = '{"all_f",   64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA};
        vecs[4] = '{"descend", 64'hFEDCBA9876543210, 64'hA970364BD21C8FE5};
        vecs[5] = '{"all_1",   64'h1111111111111111, 64'hEEEEEEEEEEEEEEEE};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out_data",  out_data,       64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].name, vecs[i].din, vecs[i].dout);
        end

        // Backpressure: result must sit still while new input is offered.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h0123456789ABCDEF;
        @(negedge clk);
        in_data  = 64'hFFFFFFFFFFFFFFFF;
        wait_out(n);
        check("bp_latency", 64'(n), 64'd16);
        held = out_data;
        check("bp_data", held, 64'h5EF8C12DB463079A);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_in_ready",   64'(in_ready),  64'd0);
            check("bp_data_hold",  out_data,       64'h5EF8C12DB463079A);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_single_xfer", 64'(out_valid), 64'd0);
        check("bp_idle",        64'(in_ready),  64'd1);
        out_ready = 1'b1;

        // Reset at cnt=7 discards the word immediately.
        in_valid = 1'b1;
        in_data  = 64'h0123456789ABCDEF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_busy",      64'(busy),      64'd0);
        check("mr_in_ready",  64'(in_ready),  64'd1);
        check("mr_out_data",  out_data,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("mr_no_output", 64'(out_valid), 64'd0);
        end
        run_word("after_rst", 64'hCCCCCCCCCCCCCCCC, 64'h0000000000000000);

        // Back-to-back: in_valid stays high across two words.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h0000000000000000;
        @(negedge clk);
        in_data  = 64'hFEDCBA9876543210;
        wait_out(n);
        check("b2b_lat_a",  64'(n), 64'd16);
        check("b2b_data_a", out_data, 64'h5555555555555555);
        @(negedge clk);
        check("b2b_no_accept_busy", 64'(busy),     64'd0);
        check("b2b_idle_ready",     64'(in_ready), 64'd1);
        @(negedge clk);
        check("b2b_accept_b", 64'(busy), 64'd1);
        in_valid = 1'b0;
        wait_out(n);
        check("b2b_lat_b",  64'(n), 64'd16);
        check("b2b_data_b", out_data, 64'hA970364BD21C8FE5);
        @(negedge clk);

        // Single-nibble build: one edge in S_BUSY.
        check("n1_idle", 64'(in_ready1), 64'd1);
        in_valid1 = 1'b1;
        in_data1  = 4'h9;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("n1_busy",      64'(busy1),      64'd1);
        check("n1_not_valid", 64'(out_valid1), 64'd0);
        @(negedge clk);
        check("n1_valid", 64'(out_valid1), 64'd1);
        check("n1_busy_done", 64'(busy1),   64'd0);
        check("n1_data",  64'(out_data1),  64'h4);
        @(negedge clk);
        check("n1_released", 64'(out_valid1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
